// File: rtl/bcd_display_mux_n.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits with per-digit
// enable, decimal point, leading-zero blanking, PWM brightness and a per-frame input snapshot.
module bcd_display_mux_n #(
    parameter int NUM_DIGITS  = 8,
    parameter int BRIGHT_BITS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    scan_tick,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_BITS-1:0]  brightness,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   AN,
    output logic                    frame_done
);

    localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [SLOT_W-1:0]      LAST_SLOT  = SLOT_W'(NUM_DIGITS - 1);
    localparam logic [BRIGHT_BITS-1:0] LAST_DWELL = '1;

    logic [SLOT_W-1:0]       slot_q, slot_d;
    logic [BRIGHT_BITS-1:0]  dwell_q, dwell_d;
    logic [4*NUM_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]   snap_en_q, snap_en_d;
    logic                    snap_lz_q, snap_lz_d;
    logic [BRIGHT_BITS-1:0]  snap_bright_q, snap_bright_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_n_q, dp_n_d;
    logic                    frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0]   suppress;
    logic                    zero_run;
    logic [3:0]              cur_bcd;
    logic                    cur_dp;
    logic                    cur_en;
    logic                    cur_supp;
    logic                    visible;
    logic                    wrap;

    // Active-low gfedcba; non-decimal codes blank all segments.
    function automatic logic [6:0] decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        suppress = '0;
        zero_run = 1'b1;
        // Walk from the most significant digit; disabled digits count as zero.
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run & (~snap_en_q[i] | (snap_bcd_q[4*i +: 4] == 4'd0));
            suppress[i] = snap_lz_q & zero_run & (i != 0);
        end

        cur_bcd  = 4'd0;
        cur_dp   = 1'b0;
        cur_en   = 1'b0;
        cur_supp = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_q == SLOT_W'(i)) begin
                cur_bcd  = snap_bcd_q[4*i +: 4];
                cur_dp   = snap_dp_q[i];
                cur_en   = snap_en_q[i];
                cur_supp = suppress[i];
            end
        end

        visible = cur_en & ~cur_supp & (dwell_q <= snap_bright_q);
        wrap    = (slot_q == LAST_SLOT) && (dwell_q == LAST_DWELL);
    end

    always_comb begin
        slot_d        = slot_q;
        dwell_d       = dwell_q;
        snap_bcd_d    = snap_bcd_q;
        snap_dp_d     = snap_dp_q;
        snap_en_d     = snap_en_q;
        snap_lz_d     = snap_lz_q;
        snap_bright_d = snap_bright_q;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_n_d        = dp_n_q;
        frame_done_d  = 1'b0;

        if (scan_tick) begin
            dwell_d = dwell_q + 1'b1;
            if (dwell_q == LAST_DWELL) begin
                slot_d = (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
            end

            // Outputs reflect the slot/dwell before this tick advances them.
            if (visible) begin
                an_d   = ~(NUM_DIGITS'(1) << slot_q);
                seg_d  = decode(cur_bcd);
                dp_n_d = ~cur_dp;
            end else begin
                an_d   = '1;
                seg_d  = 7'h7F;
                dp_n_d = 1'b1;
            end

            if (wrap) begin
                snap_bcd_d    = digits_bcd;
                snap_dp_d     = dp;
                snap_en_d     = digit_en;
                snap_lz_d     = lz_suppress;
                snap_bright_d = brightness;
                frame_done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_q        <= '0;
            dwell_q       <= '0;
            snap_bcd_q    <= '0;
            snap_dp_q     <= '0;
            snap_en_q     <= '0;
            snap_lz_q     <= 1'b0;
            snap_bright_q <= '0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_n_q        <= 1'b1;
            frame_done_q  <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            dwell_q       <= dwell_d;
            snap_bcd_q    <= snap_bcd_d;
            snap_dp_q     <= snap_dp_d;
            snap_en_q     <= snap_en_d;
            snap_lz_q     <= snap_lz_d;
            snap_bright_q <= snap_bright_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_n_q        <= dp_n_d;
            frame_done_q  <= frame_done_d;
        end
    end

    assign AN         = an_q;
    assign seg        = seg_q;
    assign dp_n       = dp_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_display_mux_n.sv
// Directed bench for bcd_display_mux_n with 4 digits and 2-bit brightness,
// scan_tick pulsed once every 4 clocks.
module tb_bcd_display_mux_n;

    localparam int N = 4;
    localparam int B = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         scan_tick;
    logic [15:0]  digits_bcd;
    logic [3:0]   dp;
    logic [3:0]   digit_en;
    logic         lz_suppress;
    logic [1:0]   brightness;
    logic [6:0]   seg;
    logic         dp_n;
    logic [3:0]   an;
    logic         frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_display_mux_n #(.NUM_DIGITS(N), .BRIGHT_BITS(B)) dut (
        .clk         (clk),
        .reset       (reset),
        .scan_tick   (scan_tick),
        .digits_bcd  (digits_bcd),
        .dp          (dp),
        .digit_en    (digit_en),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
        .seg         (seg),
        .dp_n        (dp_n),
        .AN          (an),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // segs packs slot s at [7s +: 7]; lit = slots expected to light at all.
    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic        lz;
        logic [1:0]  bright;
        logic [3:0]  lit;
        logic [27:0] segs;
        logic [3:0]  dpn;
    } vec_t;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SB = 7'b1111111;

    vec_t vecs [8];
    vec_t dark, ones, nines, prev;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input vec_t v);
        digits_bcd  = v.digits;
        dp          = v.dp;
        digit_en    = v.en;
        lz_suppress = v.lz;
        brightness  = v.bright;
    endtask

    // One scan tick: pulse, sample one clk later, then idle 3 clks.
    task automatic do_tick(input logic [3:0] an_e, input logic [6:0] seg_e,
                           input logic dpn_e, input logic fd_e);
        scan_tick = 1'b1;
        @(posedge clk);
        #1;
        scan_tick = 1'b0;
        check("an", {28'd0, an}, {28'd0, an_e});
        check("seg", {25'd0, seg}, {25'd0, seg_e});
        check("dp_n", {31'd0, dp_n}, {31'd0, dpn_e});
        check("frame_done", {31'd0, frame_done}, {31'd0, fd_e});
        @(posedge clk);
        #1;
        check("frame_done_width", {31'd0, frame_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Ticks first..last of a frame (t = 4*slot + dwell) with v in the snapshot.
    task automatic run_ticks(input vec_t v, input int first, input int last);
        logic [3:0] an_e;
        logic [6:0] seg_e;
        logic       dpn_e;
        logic       vis;
        for (int t = first; t <= last; t++) begin
            int s;
            int d;
            s     = t / 4;
            d     = t % 4;
            vis   = v.lit[s] && (d <= int'(v.bright));
            an_e  = vis ? ~(4'b0001 << s) : 4'hF;
            seg_e = vis ? v.segs[7*s +: 7] : 7'h7F;
            dpn_e = vis ? v.dpn[s] : 1'b1;
            do_tick(an_e, seg_e, dpn_e, t == 15);
        end
    endtask

    initial begin
        //        digits   dp     en     lz    br     lit      segs {s3,s2,s1,s0}      dpn
        vecs[0] = '{16'h4321, 4'h0, 4'hF, 1'b0, 2'd3, 4'b1111, {S4, S3, S2, S1}, 4'hF};
        vecs[1] = '{16'h4321, 4'h0, 4'hF, 1'b0, 2'd0, 4'b1111, {S4, S3, S2, S1}, 4'hF};
        vecs[2] = '{16'h0050, 4'h0, 4'hF, 1'b1, 2'd3, 4'b0011, {SB, SB, S5, S0}, 4'hF};
        vecs[3] = '{16'h0000, 4'h0, 4'hF, 1'b1, 2'd3, 4'b0001, {SB, SB, SB, S0}, 4'hF};
        vecs[4] = '{16'h9C99, 4'h4, 4'hF, 1'b0, 2'd3, 4'b1111, {S9, SB, S9, S9}, 4'b1011};
        vecs[5] = '{16'h8765, 4'h3, 4'hA, 1'b0, 2'd2, 4'b1010, {S8, S7, S6, S5}, 4'b1101};
        vecs[6] = '{16'h5003, 4'h0, 4'h7, 1'b1, 2'd1, 4'b0001, {SB, SB, SB, S3}, 4'hF};
        vecs[7] = '{16'h0700, 4'h0, 4'hF, 1'b1, 2'd3, 4'b0111, {SB, S7, S0, S0}, 4'hF};
        dark    = '{16'h0000, 4'h0, 4'h0, 1'b0, 2'd0, 4'b0000, {SB, SB, SB, SB}, 4'hF};
        ones    = '{16'h1111, 4'h0, 4'hF, 1'b0, 2'd3, 4'b1111, {S1, S1, S1, S1}, 4'hF};
        nines   = '{16'h9999, 4'h0, 4'hF, 1'b0, 2'd3, 4'b1111, {S9, S9, S9, S9}, 4'hF};

        // Reset with live inputs and scan_tick held high: reset must win.
        apply(vecs[0]);
        reset     = 1'b1;
        scan_tick = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_an", {28'd0, an}, 32'hF);
        check("reset_seg", {25'd0, seg}, 32'h7F);
        check("reset_dp_n", {31'd0, dp_n}, 32'd1);
        check("reset_frame_done", {31'd0, frame_done}, 32'd0);
        reset     = 1'b0;
        scan_tick = 1'b0;

        // Each vector: the frame it is applied in still shows the previous snapshot.
        prev = dark;
        for (int k = 0; k < 8; k++) begin
            apply(vecs[k]);
            run_ticks(prev, 0, 15);
            run_ticks(vecs[k], 0, 15);
            prev = vecs[k];
        end

        // Input change mid-frame (slot 1) stays invisible until the next frame.
        apply(ones);
        run_ticks(prev, 0, 15);
        run_ticks(ones, 0, 15);
        run_ticks(ones, 0, 4);
        digits_bcd = 16'h9999;
        run_ticks(ones, 5, 15);
        run_ticks(nines, 0, 15);

        // Reset while slot 2 is active, then restart from slot 0 with a dark frame.
        apply(vecs[0]);
        run_ticks(nines, 0, 15);
        run_ticks(vecs[0], 0, 7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_an", {28'd0, an}, 32'hF);
        check("midreset_seg", {25'd0, seg}, 32'h7F);
        check("midreset_frame_done", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_ticks(dark, 0, 15);
        run_ticks(vecs[0], 0, 0);

        // No scan_tick for 50 clks: outputs stay as loaded for slot 0, dwell 0.
        for (int c = 0; c < 50; c++) begin
            @(posedge clk);
            #1;
            if (c % 10 == 0) begin
                check("freeze_an", {28'd0, an}, 32'hE);
                check("freeze_seg", {25'd0, seg}, {25'd0, S1});
                check("freeze_frame_done", {31'd0, frame_done}, 32'd0);
            end
        end
        run_ticks(vecs[0], 1, 15);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
